// File: rtl/hash_des_param.sv
// Byte-serial rotate/xor/add hash core: absorbs C_in bytes, then runs
// FINAL_ROUNDS length-mixing rounds and presents a held digest.
module hash_des_param #(
  parameter int                  DIGEST_W     = 32,
  parameter int                  LEN_W        = 64,
  parameter int                  ROT          = 5,
  parameter int                  FINAL_ROUNDS = 4,
  parameter logic [DIGEST_W-1:0] IV           = DIGEST_W'(32'h0123_4567)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [LEN_W-1:0]    C_in,
  input  logic                M_valid,
  input  logic [7:0]          M,
  output logic                M_ready,
  output logic                busy,
  output logic                hash_ready,
  output logic [DIGEST_W-1:0] digest
);

  localparam int RND_W = (FINAL_ROUNDS > 1) ? $clog2(FINAL_ROUNDS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ABSORB, S_FINAL, S_DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic [DIGEST_W-1:0] r_h;
  logic [LEN_W-1:0]    r_len;
  logic [LEN_W-1:0]    r_cnt;
  logic [RND_W-1:0]    r_rnd;
  logic                r_hash_ready;
  logic [DIGEST_W-1:0] r_digest;

  logic                w_start_ok;
  logic                w_accept;
  logic                w_last_byte;
  logic                w_last_rnd;
  logic [DIGEST_W-1:0] w_h_absorb;
  logic [DIGEST_W-1:0] w_h_final;

  function automatic logic [DIGEST_W-1:0] rotl(input logic [DIGEST_W-1:0] x);
    return (x << ROT) | (x >> (DIGEST_W - ROT));
  endfunction

  assign w_start_ok  = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_accept    = M_valid && (r_state == S_ABSORB);
  // len is never 0 in ABSORB, so len-1 cannot underflow here
  assign w_last_byte = (r_cnt == r_len - LEN_W'(1));
  assign w_last_rnd  = (r_rnd == RND_W'(FINAL_ROUNDS - 1));
  assign w_h_absorb  = rotl(r_h ^ {{(DIGEST_W-8){1'b0}}, M}) + DIGEST_W'(r_cnt);
  assign w_h_final   = rotl(r_h) ^ DIGEST_W'(r_len);

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE:
        if (start) w_state_nxt = (C_in == '0) ? S_FINAL : S_ABSORB;
      S_ABSORB:
        if (M_valid && w_last_byte) w_state_nxt = S_FINAL;
      S_FINAL:
        if (w_last_rnd) w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // output logic
  always_comb begin
    M_ready = 1'b0;
    busy    = 1'b0;
    case (r_state)
      S_ABSORB: begin M_ready = 1'b1; busy = 1'b1; end
      S_FINAL:  busy = 1'b1;
      default:  ;
    endcase
  end

  assign hash_ready = r_hash_ready;
  assign digest     = r_digest;

  // datapath; rnd holds at its last value so it never passes FINAL_ROUNDS-1
  always_ff @(posedge clk) begin
    if (rst) begin
      r_h          <= IV;
      r_len        <= '0;
      r_cnt        <= '0;
      r_rnd        <= '0;
      r_hash_ready <= 1'b0;
      r_digest     <= '0;
    end else begin
      if (w_start_ok) begin
        r_len        <= C_in;
        r_h          <= IV;
        r_cnt        <= '0;
        r_rnd        <= '0;
        r_hash_ready <= 1'b0;
      end
      if (w_accept) begin
        r_h   <= w_h_absorb;
        r_cnt <= r_cnt + LEN_W'(1);
      end
      if (r_state == S_FINAL) begin
        r_h <= w_h_final;
        if (w_last_rnd) begin
          r_digest     <= w_h_final;
          r_hash_ready <= 1'b1;
        end else begin
          r_rnd <= r_rnd + RND_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_hash_des_param.sv
// Scoreboard bench for hash_des_param: two instances (default IV and IV=0)
// share stimulus; expected digests come from a reference model.
module tb_hash_des_param;

  localparam logic [31:0] IVA = 32'h0123_4567;
  localparam int          FR  = 4;

  logic        clk;
  logic        rst;
  logic        start;
  logic [63:0] C_in;
  logic        M_valid;
  logic [7:0]  M;

  logic        a_M_ready, a_busy, a_hash_ready;
  logic [31:0] a_digest;
  logic        b_M_ready, b_busy, b_hash_ready;
  logic [31:0] b_digest;

  logic [7:0]  msg [0:255];
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] d50;

  hash_des_param u_a (
    .clk(clk), .rst(rst), .start(start), .C_in(C_in), .M_valid(M_valid), .M(M),
    .M_ready(a_M_ready), .busy(a_busy), .hash_ready(a_hash_ready), .digest(a_digest)
  );

  hash_des_param #(.IV(32'h0)) u_b (
    .clk(clk), .rst(rst), .start(start), .C_in(C_in), .M_valid(M_valid), .M(M),
    .M_ready(b_M_ready), .busy(b_busy), .hash_ready(b_hash_ready), .digest(b_digest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rotl5(input logic [31:0] x);
    return {x[26:0], x[31:27]};
  endfunction

  function automatic logic [31:0] model(input logic [31:0] iv, input int n);
    logic [31:0] h;
    h = iv;
    for (int i = 0; i < n; i++) h = rotl5(h ^ {24'h0, msg[i]}) + 32'(i);
    for (int r = 0; r < FR; r++) h = rotl5(h) ^ 32'(n);
    return h;
  endfunction

  // Drives one message from the negedge; gap_mode 0 = back-to-back,
  // 1 = valid every other cycle, 2 = random gaps. Returns lat=-1 on abort.
  task automatic run_msg(input int n, input int gap_mode, input int inj_at,
                         input int abort_at, output int lat, output int gaps,
                         output logic [31:0] da);
    logic [31:0] ea, eb;
    int          sent, cyc;
    logic        vld;
    qa.push_back(model(IVA, n));
    qb.push_back(model(32'h0, n));
    start = 1'b1; C_in = 64'(n); M_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    n_vec++;
    if (a_hash_ready !== 1'b0 || b_hash_ready !== 1'b0) begin
      n_err++; $display("FAIL start_clear: hash_ready a=%b b=%b want 0", a_hash_ready, b_hash_ready);
    end
    sent = 0; cyc = 0; gaps = 0; da = 'x;
    while (a_hash_ready !== 1'b1 && cyc < 5000) begin
      if (abort_at >= 0 && sent == abort_at) begin
        void'(qa.pop_back()); void'(qb.pop_back());
        lat = -1;
        return;
      end
      if (sent < n) begin
        vld = !(gap_mode == 1 && cyc % 2 == 1) && !(gap_mode == 2 && $urandom_range(0, 2) == 0);
        if (!vld) gaps++;
        M = vld ? msg[sent] : 8'($urandom);
      end else begin
        vld = 1'b1;           // garbage outside ABSORB must be ignored
        M   = 8'($urandom);
      end
      M_valid = vld;
      if (cyc == inj_at) begin start = 1'b1; C_in = 64'd3; end
      if (vld && a_M_ready && sent < n) sent++;
      @(negedge clk);
      cyc++;
      start = 1'b0;
    end
    M_valid = 1'b0;
    lat = cyc;
    ea = qa.pop_front();
    eb = qb.pop_front();
    n_vec++;
    if (cyc >= 5000) begin
      n_err++; $display("FAIL timeout: len %0d no hash_ready after %0d cycles", n, cyc);
      return;
    end
    da = a_digest;
    n_vec++;
    if (a_digest !== ea) begin
      n_err++; $display("FAIL digest_a: len %0d got %h want %h", n, a_digest, ea);
    end
    n_vec++;
    if (b_hash_ready !== 1'b1 || b_digest !== eb) begin
      n_err++; $display("FAIL digest_b: len %0d rdy %b got %h want %h", n, b_hash_ready, b_digest, eb);
    end
    n_vec++;
    if (lat != n + FR + gaps) begin
      n_err++; $display("FAIL latency: len %0d got %0d want %0d", n, lat, n + FR + gaps);
    end
    @(negedge clk);
    n_vec++;
    if (a_hash_ready !== 1'b1 || a_digest !== ea || a_busy !== 1'b0 || a_M_ready !== 1'b0) begin
      n_err++; $display("FAIL done_hold: rdy %b dig %h busy %b mrdy %b want 1 %h 0 0",
                        a_hash_ready, a_digest, a_busy, a_M_ready, ea);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; C_in = 64'd5; M_valid = 1'b1; M = 8'hAA;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({a_M_ready, a_busy, a_hash_ready, b_M_ready, b_busy, b_hash_ready} !== 6'b0 ||
        a_digest !== 32'h0 || b_digest !== 32'h0) begin
      n_err++; $display("FAIL reset: mrdy %b busy %b rdy %b dig %h/%h want all 0",
                        a_M_ready, a_busy, a_hash_ready, a_digest, b_digest);
    end
    rst = 1'b0; start = 1'b0; M_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (a_busy !== 1'b0 || a_hash_ready !== 1'b0 || a_M_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_idle: busy %b rdy %b mrdy %b want 0", a_busy, a_hash_ready, a_M_ready);
    end
  endtask

  task automatic test_zero_len();
    int lat, gaps;
    logic [31:0] da;
    run_msg(0, 0, -1, -1, lat, gaps, da);
    n_vec++;
    if (da !== 32'h5670_1234 || lat != 4) begin
      n_err++; $display("FAIL zero_len: got %h lat %0d want 56701234 lat 4", da, lat);
    end
  endtask

  task automatic test_single_zero();
    int lat, gaps;
    logic [31:0] da;
    msg[0] = 8'h00;
    run_msg(1, 0, -1, -1, lat, gaps, da);
    n_vec++;
    if (b_digest !== 32'h0000_8421 || lat != 5) begin
      n_err++; $display("FAIL single_zero: got %h lat %0d want 00008421 lat 5", b_digest, lat);
    end
  endtask

  task automatic test_backpressure();
    int lat0, lat1, g0, g1;
    logic [31:0] d0, d1;
    for (int i = 0; i < 50; i++) msg[i] = 8'(i);
    run_msg(50, 0, -1, -1, lat0, g0, d0);
    run_msg(50, 1, -1, -1, lat1, g1, d1);
    d50 = model(IVA, 50);
    n_vec++;
    if (d0 !== d50 || d1 !== d50) begin
      n_err++; $display("FAIL backpressure_eq: b2b %h gapped %h want %h", d0, d1, d50);
    end
    n_vec++;
    if (lat0 != 54 || lat1 != 54 + g1 || g1 == 0) begin
      n_err++; $display("FAIL backpressure_lat: %0d/%0d gaps %0d want 54/%0d", lat0, lat1, g1, 54 + g1);
    end
  endtask

  task automatic test_start_busy();
    int lat, gaps;
    logic [31:0] da;
    run_msg(50, 0, 25, -1, lat, gaps, da);
    n_vec++;
    if (da !== d50) begin
      n_err++; $display("FAIL start_busy: got %h want %h", da, d50);
    end
  endtask

  task automatic test_reset_mid();
    int lat, gaps;
    logic [31:0] da;
    run_msg(50, 0, -1, 20, lat, gaps, da);
    rst = 1'b1;               // M_valid still high: reset must win
    @(negedge clk);
    rst = 1'b0; M_valid = 1'b0;
    n_vec++;
    if (lat != -1 || a_busy !== 1'b0 || a_hash_ready !== 1'b0 || a_M_ready !== 1'b0 || a_digest !== 32'h0) begin
      n_err++; $display("FAIL reset_mid: lat %0d busy %b rdy %b mrdy %b dig %h want idle",
                        lat, a_busy, a_hash_ready, a_M_ready, a_digest);
    end
    @(negedge clk);
    run_msg(50, 2, -1, -1, lat, gaps, da);
    n_vec++;
    if (da !== d50) begin
      n_err++; $display("FAIL reset_restart: got %h want %h", da, d50);
    end
  endtask

  task automatic test_random();
    int lat, gaps, n;
    logic [31:0] da;
    for (int k = 0; k < 4; k++) begin
      n = $urandom_range(1, 120);
      for (int i = 0; i < n; i++) msg[i] = 8'($urandom);
      run_msg(n, k % 3, (k == 1) ? 5 : -1, -1, lat, gaps, da);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; C_in = '0; M_valid = 1'b0; M = '0;
    @(negedge clk);
    test_reset();
    test_zero_len();
    test_single_zero();
    test_backpressure();
    test_start_busy();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hash_des_param.md
HASH_DES_PARAM -- requirements
Module: hash_des_param

Interface
REQ-001 The module SHALL provide parameter DIGEST_W, default 32, meaning digest/state width in bits (multiple of 8, minimum 16).
REQ-002 The module SHALL provide parameter LEN_W, default 64, meaning the width of the message-length field in bytes.
REQ-003 The module SHALL provide parameter ROT, default 5, meaning the left-rotate amount per step (1..DIGEST_W-1).
REQ-004 The module SHALL provide parameter FINAL_ROUNDS, default 4, meaning the number of finalisation rounds (at least 1).
REQ-005 The module SHALL provide parameter IV, default 32'h0123_4567 zero-extended to DIGEST_W, meaning the initial state value.
REQ-006 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 The module SHALL have port start, input, 1 bit: begin a new message, sampled with C_in.
REQ-009 The module SHALL have port C_in, input, LEN_W bits: message length in bytes, latched on an accepted start.
REQ-010 The module SHALL have port M_valid, input, 1 bit: message byte valid.
REQ-011 The module SHALL have port M, input, 8 bits: message byte.
REQ-012 The module SHALL have port M_ready, output, 1 bit: the core accepts a byte this cycle.
REQ-013 The module SHALL have port busy, output, 1 bit: the core is in ABSORB or FINAL.
REQ-014 The module SHALL have port hash_ready, output, 1 bit: digest is valid.
REQ-015 The module SHALL have port digest, output, DIGEST_W bits: the hash result.

Function
REQ-016 The FSM states SHALL be IDLE, ABSORB, FINAL and DONE; internal registers SHALL be H (DIGEST_W), len (LEN_W), cnt (LEN_W) and rnd (counter up to FINAL_ROUNDS).
REQ-017 In IDLE or DONE, start=1 SHALL set len=C_in, H=IV, cnt=0, rnd=0 and hash_ready=0, then go to ABSORB, or to FINAL if C_in==0.
REQ-018 In ABSORB and FINAL, start SHALL be ignored.
REQ-019 M_ready SHALL be 1 exactly when the state is ABSORB, and M_valid outside ABSORB SHALL be ignored.
REQ-020 A byte SHALL be accepted when M_valid && M_ready; on acceptance, H <= rotl(H ^ zext(M), ROT) + zext(cnt) (mod 2^DIGEST_W, where zext(cnt) keeps the low DIGEST_W bits of cnt), and cnt <= cnt+1.
REQ-021 When a byte is accepted with cnt==len-1, the FSM SHALL go to FINAL; when M_valid=0 it SHALL stall with no state change.
REQ-022 Each FINAL cycle SHALL compute H <= rotl(H, ROT) ^ zext(len[DIGEST_W-1:0]) and rnd <= rnd+1.
REQ-023 On the FINAL cycle with rnd==FINAL_ROUNDS-1, digest SHALL load the new H value, hash_ready SHALL become 1, and the FSM SHALL go to DONE.
REQ-024 DONE SHALL hold hash_ready=1 and digest stable until start or rst; start in DONE SHALL clear hash_ready on the next edge.
REQ-025 Latency: with back-to-back bytes, hash_ready SHALL rise exactly N+FINAL_ROUNDS edges after the edge that samples start (N = C_in), and byte gaps SHALL add one cycle per idle cycle.
REQ-026 busy SHALL equal (state==ABSORB || state==FINAL).
REQ-027 The digest SHALL be independent of M_valid gap pattern and depend only on IV, the byte sequence and len.
REQ-028 C_in = 2^LEN_W-1 SHALL be legal, cnt SHALL never wrap before reaching len, and rnd SHALL never exceed FINAL_ROUNDS-1.

Reset
REQ-029 rst=1 at a rising edge SHALL force state=IDLE, H=IV, len=0, cnt=0, rnd=0, M_ready=0, busy=0, hash_ready=0 and digest=0, and SHALL take priority over start and M_valid.
REQ-030 rst asserted mid-ABSORB or mid-FINAL SHALL abandon the message with no digest update, and a new start after reset SHALL hash from IV.

Verification
REQ-031 The bench SHALL cover reset: rst=1 for 2 cycles with start=1 and M_valid=1 -> all outputs 0, M_ready=0, state IDLE.
REQ-032 The bench SHALL cover zero length: DIGEST_W=32, IV=32'h01234567, ROT=5, FINAL_ROUNDS=4, start with C_in=0 -> no byte accepted, hash_ready after 4 edges, digest=32'h56701234.
REQ-033 The bench SHALL cover a single zero byte: IV=0, ROT=5, FINAL_ROUNDS=4, C_in=1, M=8'h00 -> digest=32'h00008421, hash_ready after 5 edges.
REQ-034 The bench SHALL cover backpressure equivalence: C_in=50, M=0..49, sent once back-to-back and once with M_valid toggling every other cycle -> identical digest (equal to the bit-accurate model), with latency 54 and 54+gaps edges.
REQ-035 The bench SHALL cover a start during busy: start pulsed with C_in=3 in the middle of a 50-byte message -> ignored, and the 50-byte digest is unchanged.
REQ-036 The bench SHALL cover reset mid-message: rst after 20 of 50 bytes -> IDLE, hash_ready=0; then restart with the same 50 bytes -> digest equals the REQ-034 value.
